// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// State encoding, default bus widths and a counter-width helper.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 64;
    localparam int DMEM_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PIPE = 2'd1,
        ST_AUX  = 2'd2
    } arb_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = pipeline/aux/memory environment view.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic              pipe_req;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_done;
    logic              pipe_stall;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_done;

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;

    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output pipe_rdata, pipe_done, pipe_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_rdata, aux_done,
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData
    );

    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  pipe_rdata, pipe_done, pipe_stall,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_rdata, aux_done,
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData
    );

endinterface

// File: rtl/dmem_arb_lat_cnt.sv
// Memory-latency down-counter: loads MEM_LAT-1 on grant,
// counts down while an access is active, flags terminal count at zero.
module dmem_arb_lat_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic tc_o
);
    localparam int CW = cnt_w(MEM_LAT);
    localparam logic [CW-1:0] LOAD_V = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_V;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage (primary) vs aux port, fixed latency.
// Optional perf counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int MEM_LAT        = 1,
    parameter int AUX_STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    dmem_arbiter_if.slave bus,
    output logic [31:0]  perf_stall_cycles,
    output logic [15:0]  perf_aux_grants
);
    localparam int SW = cnt_w(AUX_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(AUX_STARVE_MAX);

    arb_state_e        state_q;
    logic [SW-1:0]     starve_q;
    logic              rd_q;
    logic              wr_q;
    logic              pdone_q;
    logic              adone_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] ardata_q;

    logic idle;
    logic pipe_gnt;
    logic aux_gnt;
    logic lat_tc;
    logic stall;

    assign idle = (state_q == ST_IDLE);

    // Flush only masks the pipe request in the arbitration cycle.
    assign pipe_gnt = idle && bus.pipe_req && !flush &&
                      (!bus.aux_req || starve_q < STARVE_MAX);
    assign aux_gnt  = idle && bus.aux_req && !pipe_gnt;

    dmem_arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pipe_gnt || aux_gnt),
        .dec_i  (!idle),
        .tc_o   (lat_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            pdone_q  <= 1'b0;
            adone_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prdata_q <= '0;
            ardata_q <= '0;
        end else begin
            pdone_q <= 1'b0;
            adone_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pipe_gnt) begin
                        state_q <= ST_PIPE;
                        rd_q    <= !bus.pipe_we;
                        wr_q    <= bus.pipe_we;
                        addr_q  <= bus.pipe_addr;
                        wdata_q <= bus.pipe_wdata;
                        if (bus.aux_req && starve_q < STARVE_MAX)
                            starve_q <= starve_q + SW'(1);
                    end else if (aux_gnt) begin
                        state_q  <= ST_AUX;
                        rd_q     <= !bus.aux_we;
                        wr_q     <= bus.aux_we;
                        addr_q   <= bus.aux_addr;
                        wdata_q  <= bus.aux_wdata;
                        starve_q <= '0;
                    end
                end
                ST_PIPE: begin
                    if (lat_tc) begin
                        state_q <= ST_IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        pdone_q <= 1'b1;
                        if (rd_q)
                            prdata_q <= bus.ReadData;
                    end
                end
                ST_AUX: begin
                    if (lat_tc) begin
                        state_q <= ST_IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        adone_q <= 1'b1;
                        if (rd_q)
                            ardata_q <= bus.ReadData;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall          = bus.pipe_req && !pdone_q;
    assign bus.pipe_stall = stall;
    assign bus.pipe_done  = pdone_q;
    assign bus.pipe_rdata = prdata_q;
    assign bus.aux_done   = adone_q;
    assign bus.aux_rdata  = ardata_q;
    assign bus.MemRead    = rd_q;
    assign bus.MemWrite   = wr_q;
    assign bus.Address    = addr_q;
    assign bus.WriteData  = wdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] aux_gnt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            aux_gnt_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (aux_gnt && aux_gnt_cnt_q != '1)
                aux_gnt_cnt_q <= aux_gnt_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_aux_grants   = aux_gnt_cnt_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_aux_grants   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (MEM_LAT=3, AUX_STARVE_MAX=4).
// Directed steps followed by random requester traffic vs a cycle model.
module tb_dmem_arbiter;
    localparam int MEM_LAT = 3;
    localparam int MAXS    = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        mem_init;
    logic [31:0] perf_stall;
    logic [15:0] perf_aux;
    logic [63:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_arbiter #(
        .ADDR_W         (64),
        .DATA_W         (64),
        .MEM_LAT        (MEM_LAT),
        .AUX_STARVE_MAX (MAXS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .bus               (bus),
        .perf_stall_cycles (perf_stall),
        .perf_aux_grants   (perf_aux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 16) ? 64'hDEAD_BEEF : 64'h0;
        end else if (bus.MemWrite) begin
            mem[bus.Address[5:0]] <= bus.WriteData;
        end
    end
    assign bus.ReadData = mem[bus.Address[5:0]];

    // Reference model: expected outputs of the current cycle.
    logic [63:0] ref_mem [0:63];
    bit          e_rd = 0, e_wr = 0, e_pdone = 0, e_adone = 0;
    logic [63:0] e_addr = 0, e_wdata = 0, e_prdata = 0, e_ardata = 0;
    int          rem = 0;
    int          starve = 0;
    bit          owner_aux = 0;
    longint      p_stall = 0;
    int          p_aux = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        bit pg;
        if (!rst_n) begin
            if (e_wr) ref_mem[e_addr[5:0]] = e_wdata;
            e_rd = 0; e_wr = 0; e_pdone = 0; e_adone = 0;
            e_addr = 0; e_wdata = 0; e_prdata = 0; e_ardata = 0;
            rem = 0; starve = 0; p_stall = 0; p_aux = 0;
            return;
        end
        if (bus.pipe_req && !e_pdone && p_stall < 64'hFFFF_FFFF)
            p_stall++;
        e_pdone = 0;
        e_adone = 0;
        if (rem > 0) begin
            if (rem == 1) begin
                if (e_wr) ref_mem[e_addr[5:0]] = e_wdata;
                else if (owner_aux) e_ardata = ref_mem[e_addr[5:0]];
                else e_prdata = ref_mem[e_addr[5:0]];
                if (owner_aux) e_adone = 1;
                else e_pdone = 1;
                e_rd = 0;
                e_wr = 0;
            end
            rem--;
        end else begin
            pg = bus.pipe_req && !flush && (!bus.aux_req || starve < MAXS);
            if (pg) begin
                owner_aux = 0;
                e_wr = bus.pipe_we; e_rd = !bus.pipe_we;
                e_addr = bus.pipe_addr; e_wdata = bus.pipe_wdata;
                rem = MEM_LAT;
                if (bus.aux_req && starve < MAXS) starve++;
            end else if (bus.aux_req) begin
                owner_aux = 1;
                e_wr = bus.aux_we; e_rd = !bus.aux_we;
                e_addr = bus.aux_addr; e_wdata = bus.aux_wdata;
                rem = MEM_LAT;
                starve = 0;
                if (p_aux < 65535) p_aux++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("MemRead", bus.MemRead, e_rd);
        chk("MemWrite", bus.MemWrite, e_wr);
        chk("Address", bus.Address, e_addr);
        chk("WriteData", bus.WriteData, e_wdata);
        chk("pipe_done", bus.pipe_done, e_pdone);
        chk("aux_done", bus.aux_done, e_adone);
        chk("pipe_rdata", bus.pipe_rdata, e_prdata);
        chk("aux_rdata", bus.aux_rdata, e_ardata);
        chk("pipe_stall", bus.pipe_stall, bus.pipe_req && !e_pdone);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", perf_stall, p_stall);
        chk("perf_aux", perf_aux, p_aux);
`else
        chk("perf_stall_off", perf_stall, 0);
        chk("perf_aux_off", perf_aux, 0);
`endif
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wait_done(input bit aux, output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = aux ? bus.aux_done : bus.pipe_done;
        end
        chk(aux ? "aux_done_seen" : "pipe_done_seen", seen, 1);
    endtask

    task automatic new_pipe_op();
        bus.pipe_we    = $urandom_range(0, 1);
        bus.pipe_addr  = 64'($urandom_range(0, 63));
        bus.pipe_wdata = {$urandom, $urandom};
    endtask

    task automatic new_aux_op();
        bus.aux_we    = $urandom_range(0, 1);
        bus.aux_addr  = 64'($urandom_range(0, 63));
        bus.aux_wdata = {$urandom, $urandom};
    endtask

    initial begin
        int n;
        int k;
        logic [9:0] order;

        for (int i = 0; i < 64; i++)
            ref_mem[i] = (i == 16) ? 64'hDEAD_BEEF : 64'h0;
        rst_n = 0; flush = 0; mem_init = 1;
        bus.pipe_req = 0; bus.pipe_we = 0;
        bus.pipe_addr = 0; bus.pipe_wdata = 0;
        bus.aux_req = 0; bus.aux_we = 0;
        bus.aux_addr = 0; bus.aux_wdata = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_memread", bus.MemRead, 0);
        chk("rst_pipe_rdata", bus.pipe_rdata, 0);
        rst_n = 1; mem_init = 0;
        tick();

        // Pipe load of preloaded word
        bus.pipe_req = 1; bus.pipe_we = 0; bus.pipe_addr = 64'h10;
        wait_done(0, n);
        bus.pipe_req = 0;
        chk("load_latency", n, MEM_LAT + 1);
        chk("load_data", bus.pipe_rdata, 64'hDEAD_BEEF);

        // Aux store then pipe load of the same address
        bus.aux_req = 1; bus.aux_we = 1;
        bus.aux_addr = 64'h20; bus.aux_wdata = 64'h55;
        wait_done(1, n);
        bus.aux_req = 0;
        chk("aux_store_latency", n, MEM_LAT + 1);
        bus.pipe_req = 1; bus.pipe_we = 0; bus.pipe_addr = 64'h20;
        wait_done(0, n);
        bus.pipe_req = 0;
        chk("rd_after_aux_wr", bus.pipe_rdata, 64'h55);

        // Both requesters held: starvation guard forces aux every 5th
        bus.pipe_req = 1; bus.pipe_we = 0; bus.pipe_addr = 64'h08;
        bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 64'h10;
        order = '0; k = 0; n = 0;
        while (k < 10 && n < 200) begin
            tick();
            n++;
            if (bus.pipe_done) k++;
            else if (bus.aux_done) begin order[k] = 1'b1; k++; end
        end
        bus.pipe_req = 0; bus.aux_req = 0;
        chk("grant_count", k, 10);
        chk("grant_order", order, 10'h210);

        // Flush in IDLE blocks grant; flush during access does not
        bus.pipe_req = 1; flush = 1;
        repeat (3) tick();
        chk("flush_nogrant", {bus.MemRead, bus.MemWrite}, 0);
        flush = 0; bus.pipe_we = 1;
        bus.pipe_addr = 64'h30; bus.pipe_wdata = 64'hA5A5;
        tick();
        chk("store_started", bus.MemWrite, 1);
        flush = 1;
        wait_done(0, n);
        flush = 0; bus.pipe_req = 0;
        tick();
        bus.pipe_req = 1; bus.pipe_we = 0;
        wait_done(0, n);
        bus.pipe_req = 0;
        chk("flushed_store_kept", bus.pipe_rdata, 64'hA5A5);

        // Reset during a pipe load
        bus.pipe_req = 1; bus.pipe_addr = 64'h10;
        tick();
        tick();
        chk("midrst_busy", bus.MemRead, 1);
        rst_n = 0; bus.pipe_req = 0;
        tick();
        chk("midrst_memread", bus.MemRead, 0);
        chk("midrst_done", bus.pipe_done, 0);
        chk("midrst_rdata", bus.pipe_rdata, 0);
        rst_n = 1;
        tick();

        // Random traffic
        repeat (800) begin
            flush = ($urandom_range(0, 9) == 0);
            tick();
            if (bus.pipe_done || !bus.pipe_req) begin
                bus.pipe_req = ($urandom_range(0, 2) != 0);
                new_pipe_op();
            end
            if (bus.aux_done || !bus.aux_req) begin
                bus.aux_req = ($urandom_range(0, 2) != 0);
                new_aux_op();
            end
        end
        bus.pipe_req = 0; bus.aux_req = 0; flush = 0;
        repeat (MEM_LAT + 3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
